// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the frame sequencer
// Purpose: phase enum, row count, LFSR tap mask and a counter-width helper
//          shared by frame_sequencer and row_scanner.
// Ports:   none (package)
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } phase_t;

    localparam int ROWS = 16;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Width of a counter spanning 0..n-1; never below one bit so n=1 stays legal
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_scanner.sv
// rtl/row_scanner.sv - row dwell counter, scan row and frame boundary pulse
// Purpose: holds each row for ROW_DWELL clocks, steps ROW 0..N_ROWS-1 and
//          pulses frame_start on the first cycle of row 0.
// Ports:   CLK         in   system clock
//          RST         in   asynchronous active-high reset
//          ROW         out  current scan row
//          frame_start out  1-cycle frame boundary pulse
module row_scanner
    import game_pkg::*;
#(
    parameter int N_ROWS    = ROWS,
    parameter int ROW_DWELL = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [3:0] ROW,
    output logic       frame_start
);

    localparam int            DW         = cnt_width(ROW_DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);
    localparam logic [3:0]    ROW_LAST   = 4'(N_ROWS - 1);

    logic [DW-1:0] dwell;
    // High from reset until the first clock after release, so the first
    // frame after reset is announced without waiting a full frame.
    logic          boot;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dwell       <= '0;
            ROW         <= '0;
            frame_start <= 1'b0;
            boot        <= 1'b1;
        end else begin
            boot        <= 1'b0;
            frame_start <= boot;
            if (dwell == DWELL_LAST) begin
                dwell <= '0;
                if (ROW == ROW_LAST) begin
                    ROW         <= '0;
                    frame_start <= 1'b1;
                end else begin
                    ROW <= ROW + 4'd1;
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - LED-matrix master timing and game-step sequencer
// Purpose: row scan, frame pulse, game-step request/ack handshake with a
//          periodic pseudo-random spawn column, and run/idle/over phase.
// Ports:   CLK          in   system clock
//          RST          in   asynchronous active-high reset
//          start        in   level, IDLE/OVER -> RUN
//          game_over    in   level, RUN -> OVER
//          step_ack     in   1-cycle accept of step_req
//          ROW          out  current scan row
//          frame_start  out  1-cycle pulse on first cycle of row 0
//          step_req     out  game-step request, held until acked
//          spawn_valid  out  qualifies spawn_col while step_req=1
//          spawn_col    out  asteroid column for this step
//          step_overrun out  1-cycle pulse, step due while request pending
//          running      out  1 in RUN
module frame_sequencer
    import game_pkg::*;
#(
    parameter int         ROW_DWELL       = 1024,
    parameter int         FRAMES_PER_STEP = 8,
    parameter int         SPAWN_EVERY     = 4,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       game_over,
    input  logic       step_ack,
    output logic [3:0] ROW,
    output logic       frame_start,
    output logic       step_req,
    output logic       spawn_valid,
    output logic [3:0] spawn_col,
    output logic       step_overrun,
    output logic       running
);

    localparam int            FW         = cnt_width(FRAMES_PER_STEP);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);
    localparam int            SW         = cnt_width(SPAWN_EVERY);
    localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_EVERY - 1);

    phase_t        phase;
    phase_t        phase_nxt;
    logic [7:0]    lfsr;
    logic [FW-1:0] frame_cnt;
    logic [SW-1:0] step_cnt;
    logic          enter_run;
    logic          leave_run;
    logic          step_due;

    row_scanner #(
        .N_ROWS    (ROWS),
        .ROW_DWELL (ROW_DWELL)
    ) u_row_scanner (
        .CLK         (CLK),
        .RST         (RST),
        .ROW         (ROW),
        .frame_start (frame_start)
    );

    // Free-running in every phase so spawn columns differ game to game.
    // The all-zero state is unreachable from a non-zero seed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase <= IDLE;
        end else begin
            phase <= phase_nxt;
        end
    end

    // game_over outranks start in every phase
    always_comb begin
        phase_nxt = phase;
        enter_run = 1'b0;
        leave_run = 1'b0;
        step_due  = 1'b0;
        case (phase)
            IDLE: if (start && !game_over) phase_nxt = RUN;
            RUN:  if (game_over)           phase_nxt = OVER;
            OVER: if (start && !game_over) phase_nxt = RUN;
            default:                       phase_nxt = IDLE;
        endcase
        enter_run = (phase != RUN) && (phase_nxt == RUN);
        leave_run = (phase == RUN) && (phase_nxt != RUN);
        step_due  = (phase == RUN) && frame_start && (frame_cnt == FRAME_LAST);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_cnt    <= '0;
            step_cnt     <= '0;
            step_req     <= 1'b0;
            spawn_valid  <= 1'b0;
            spawn_col    <= '0;
            step_overrun <= 1'b0;
        end else begin
            step_overrun <= 1'b0;
            if (enter_run) begin
                frame_cnt   <= '0;
                step_cnt    <= '0;
                step_req    <= 1'b0;
                spawn_valid <= 1'b0;
            end else if (leave_run) begin
                // Pending request is abandoned; a same-cycle ack is moot.
                step_req    <= 1'b0;
                spawn_valid <= 1'b0;
            end else if (phase == RUN) begin
                if (frame_start) begin
                    frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
                end
                // An ack arriving with a due step retires the old request and
                // immediately issues the new one, so it is not an overrun.
                if (step_due && (!step_req || step_ack)) begin
                    step_req    <= 1'b1;
                    spawn_valid <= (step_cnt == '0);
                    if (step_cnt == '0) begin
                        spawn_col <= lfsr[3:0];
                    end
                    step_cnt <= (step_cnt == SPAWN_LAST) ? '0 : step_cnt + SW'(1);
                end else if (step_due) begin
                    step_overrun <= 1'b1;
                end else if (step_req && step_ack) begin
                    step_req    <= 1'b0;
                    spawn_valid <= 1'b0;
                end
            end
        end
    end

    assign running = (phase == RUN);

endmodule
